// File: rtl/pump_request_arbiter.sv
// Pump request arbiter: three edge-triggered requesters share one pump, ON for on_time_s then COOLDOWN.
// Define PUMP_ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority 0 > 1 > 2 otherwise.
module pump_request_arbiter #(
  parameter int unsigned CLOCK_FREQ = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
  input  logic [1:0] sel2,
  input  logic [7:0] on_time_s,
  input  logic [7:0] cooldown_s,
  input  logic       abort,
  output logic [1:0] pump_out,
  output logic [2:0] grant,
  output logic [2:0] pending,
  output logic       busy,
  output logic       done,
  output logic       drop
);

  localparam int unsigned PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_FREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ON       = 2'b01,
    ST_COOLDOWN = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      req_prev_q, req_prev_d;
  logic            abort_prev_q, abort_prev_d;
  logic [2:0]      pending_q, pending_d;
  logic [1:0]      pump_q, pump_d;
  logic [2:0]      grant_q, grant_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      sec_q, sec_d;

  logic [2:0]      req_rise;
  logic            abort_rise;
  logic            win_valid;
  logic [1:0]      win_idx;
  logic [1:0]      win_sel;
  logic            sec_tick;
  logic [7:0]      limit;
  logic [8:0]      sec_next;
  logic            terminal;
  logic [PW-1:0]   presc_adv;
  logic [7:0]      sec_adv;

`ifdef PUMP_ARB_ROUND_ROBIN_EN
  logic [1:0]      last_q, last_d;
  logic [1:0]      cand;
`endif

  assign req_rise   = req & ~req_prev_q;
  assign abort_rise = abort & ~abort_prev_q;

  // Winner is taken from already-latched requests only; same-cycle edges wait one cycle.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
`ifdef PUMP_ARB_ROUND_ROBIN_EN
    cand      = 2'd0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(last_q) + k) % 32'd3);
      if (!win_valid && pending_q[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
`else
    if (pending_q[0]) begin
      win_valid = 1'b1;
      win_idx   = 2'd0;
    end else if (pending_q[1]) begin
      win_valid = 1'b1;
      win_idx   = 2'd1;
    end else if (pending_q[2]) begin
      win_valid = 1'b1;
      win_idx   = 2'd2;
    end
`endif
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_sel = sel0;
      2'd1:    win_sel = sel1;
      default: win_sel = sel2;
    endcase
  end

  // Terminal compare uses the live duration inputs; zero means the interval ends now.
  always_comb begin
    sec_tick  = (presc_q == PRESC_LAST);
    limit     = (state_q == ST_ON) ? on_time_s : cooldown_s;
    sec_next  = {1'b0, sec_q} + 9'd1;
    terminal  = (sec_q >= limit) || (sec_tick && (sec_next >= {1'b0, limit}));
    if (sec_tick) begin
      presc_adv = '0;
      sec_adv   = (sec_q == 8'hFF) ? sec_q : sec_next[7:0];
    end else begin
      presc_adv = presc_q + PW'(1);
      sec_adv   = sec_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_prev_d   = req;
    abort_prev_d = abort;
    pending_d    = pending_q | req_rise;
    pump_d       = pump_q;
    grant_d      = grant_q;
    done_d       = 1'b0;
    drop_d       = 1'b0;
    presc_d      = presc_adv;
    sec_d        = sec_adv;
`ifdef PUMP_ARB_ROUND_ROBIN_EN
    last_d       = last_q;
`endif

    if (abort_rise) begin
      pending_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        sec_d   = '0;
        if (!abort_rise && win_valid) begin
          pending_d[win_idx] = 1'b0;
          if (on_time_s == 8'd0) begin
            drop_d = 1'b1;
          end else begin
            state_d = ST_ON;
            pump_d  = win_sel;
            grant_d = 3'b001 << win_idx;
`ifdef PUMP_ARB_ROUND_ROBIN_EN
            last_d  = win_idx;
`endif
          end
        end
      end
      ST_ON: begin
        if (abort_rise || terminal) begin
          state_d = ST_COOLDOWN;
          pump_d  = '0;
          grant_d = '0;
          done_d  = 1'b1;
          presc_d = '0;
          sec_d   = '0;
        end
      end
      ST_COOLDOWN: begin
        if (terminal) begin
          state_d = ST_IDLE;
          presc_d = '0;
          sec_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pump_d  = '0;
        grant_d = '0;
        presc_d = '0;
        sec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_prev_q   <= '0;
      abort_prev_q <= 1'b0;
      pending_q    <= '0;
      pump_q       <= '0;
      grant_q      <= '0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      presc_q      <= '0;
      sec_q        <= '0;
`ifdef PUMP_ARB_ROUND_ROBIN_EN
      last_q       <= 2'd2;
`endif
    end else begin
      state_q      <= state_d;
      req_prev_q   <= req_prev_d;
      abort_prev_q <= abort_prev_d;
      pending_q    <= pending_d;
      pump_q       <= pump_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
`ifdef PUMP_ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign pump_out = pump_q;
  assign grant    = grant_q;
  assign pending  = pending_q;
  assign busy     = (state_q == ST_ON) || (state_q == ST_COOLDOWN);
  assign done     = done_q;
  assign drop     = drop_q;

endmodule

// File: doc/pump_request_arbiter.md
PUMP_REQUEST_ARBITER -- requirements
Module: pump_request_arbiter

Interface
REQ-001 Parameter CLOCK_FREQ, default 1_000_000, clk cycles per second.
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-004 req  in  3  level requests: [0] manual button, [1] humidity threshold, [2] periodic timer.
REQ-005 sel0, sel1, sel2  in  2 each  pump select per requester (01, 10, 11; 00 = none).
REQ-006 on_time_s  in  8  pump on duration, seconds.
REQ-007 cooldown_s  in  8  mandatory off gap after each pulse, seconds.
REQ-008 abort  in  1  stop request; rising edge is significant.
REQ-009 pump_out  out  2  pump drive.
REQ-010 grant  out  3  one-hot owner while ON, else 000.
REQ-011 pending  out  3  latched, not-yet-served requests.
REQ-012 busy  out  1  high in ON or COOLDOWN.
REQ-013 done  out  1  one-cycle pulse on the first COOLDOWN cycle.
REQ-014 drop  out  1  one-cycle pulse when a request is discarded because on_time_s==0.

Function
REQ-015 Edge detection: registered previous value per req bit and abort; a rising edge is a cycle with input 1 and previous value 0.
REQ-016 Rising edge on req[i] sets pending[i] at the next edge, in any state; a held-high req does not re-trigger.
REQ-017 States: IDLE, ON, COOLDOWN; 2-bit encoding; unused code returns to IDLE.
REQ-018 IDLE: if pending!=0, select winner; winner's pending bit cleared, sel latched to pump_out, grant set, state ON, all in one edge.
REQ-019 Latency: req high at edge n gives pending at edge n+1 and pump_out/grant at edge n+2.
REQ-020 Winner selection is fixed priority 0 > 1 > 2; simultaneous edges resolve by priority, losers stay pending.
REQ-021 Internal 1-second prescaler restarts on ON and COOLDOWN entry; ON lasts exactly on_time_s*CLOCK_FREQ cycles.
REQ-022 Latched select is held for all of ON; sel changes mid-ON are ignored; latched 00 runs the full timing with pump_out=00.
REQ-023 ON expiry: pump_out=00, grant=000, done=1, state COOLDOWN.
REQ-024 COOLDOWN lasts cooldown_s*CLOCK_FREQ cycles, minimum 1 cycle when cooldown_s==0, then IDLE.
REQ-025 Requests arriving during ON/COOLDOWN, including from the current owner, stay pending and are served after COOLDOWN.
REQ-026 on_time_s==0 at selection: winner's pending bit cleared, drop=1, no grant, state stays IDLE.
REQ-027 Abort edge in ON: next edge pump_out=00, grant=000, done=1, state COOLDOWN, pending cleared.
REQ-028 Abort edge in IDLE or COOLDOWN: pending cleared, state unchanged.
REQ-029 Abort edge has precedence over a simultaneous req edge or timer expiry in the same cycle; the simultaneous req edge is discarded.
REQ-030 on_time_s/cooldown_s are sampled each cycle; a change mid-interval applies to the terminal compare immediately.
REQ-031 Counters sized for 255*CLOCK_FREQ without overflow; no wrap-around.

Reset
REQ-032 rst_n low at a clk edge: state IDLE, pump_out=00, grant=000, pending=000, busy=0, done=0, drop=0, counters and prescaler 0, edge registers 0.
REQ-033 Reset mid-ON turns the pump off at that edge; no done pulse is emitted.
REQ-034 First cycle after reset release: req or abort already high counts as a rising edge.

Configuration
REQ-035 Macro PUMP_ARB_ROUND_ROBIN_EN defined: selection is round-robin starting after the last granted index (initial last = 2, so index 0 first after reset).
REQ-036 Macro undefined: fixed priority per REQ-020; no round-robin pointer is instantiated.

Verification (CLOCK_FREQ=10)
REQ-037 req[1] edge, on_time_s=3, cooldown_s=2, sel1=10 -> pump_out=10 at n+2 for 30 cycles, done pulse, busy low 20 cycles later.
REQ-038 req[0] and req[2] edges same cycle -> grant=001 first; grant=100 after cooldown (fixed); with round-robin enabled, a second req[0] edge during that cooldown is served after index 2.
REQ-039 Abort 5 cycles into ON with req[2] pending -> pump_out=00 next edge, done=1, pending=000, cooldown runs, then IDLE.
REQ-040 on_time_s=0, req[0] edge -> drop pulse, pump_out stays 00, busy stays 0.
REQ-041 rst_n low mid-ON -> all outputs reset values at that edge; no done pulse.
REQ-042 cooldown_s=0 -> COOLDOWN exactly 1 cycle; pending req[1] granted on the following edge.
